// File: rtl/reg_file_sb_pkg.sv
// Shared definitions for the multi-port register file with busy scoreboard.
package reg_file_pkg;

    localparam int DEF_DW   = 32;
    localparam int DEF_NREG = 32;
    localparam int DEF_NR   = 2;
    localparam int DEF_NW   = 2;

    // Architectural zero register: reads 0, ignores writes and busy marks.
    localparam int REG_ZERO = 0;

    // Bit offset of port 'port' inside a flattened bus of 'width'-bit fields.
    function automatic int port_slice(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// Issue/writeback bus of the register file: read ports, write ports,
// scoreboard controls and busy status.
interface reg_file_sb_if
    import reg_file_pkg::*;
#(
    parameter int  DW   = DEF_DW,
    parameter int  NREG = DEF_NREG,
    parameter int  NR   = DEF_NR,
    parameter int  NW   = DEF_NW,
    localparam int AW   = $clog2(NREG)
);

    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]    rd_busy;
    logic [NW-1:0]    wr_en;
    logic [NW*AW-1:0] wr_addr;
    logic [NW*DW-1:0] wr_data;
    logic             sb_set;
    logic [AW-1:0]    sb_addr;
    logic             sb_flush;
    logic [AW:0]      busy_cnt;
    logic             any_busy;

    // Issue/writeback side that drives the file.
    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, sb_set, sb_addr, sb_flush,
        input  rd_data, rd_busy, busy_cnt, any_busy
    );

    // The register file itself.
    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, sb_set, sb_addr, sb_flush,
        output rd_data, rd_busy, busy_cnt, any_busy
    );

endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// Per-register busy vector with flush/set/clear precedence and an
// incrementally maintained busy counter.
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int  NREG = DEF_NREG,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NREG-1:0] i_set_mask,
    input  logic [NREG-1:0] i_clr_mask,
    input  logic            i_flush,
    output logic [NREG-1:0] o_busy,
    output logic [AW:0]     o_busy_cnt,
    output logic            o_any_busy
);

    localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_next;
    logic [AW:0]     r_cnt;
    logic [AW:0]     w_cnt_next;

    // Next busy vector: flush beats set, set beats a same-cycle writeback clear.
    always_comb begin
        w_busy_next = '0;
        if (!i_flush) begin
            w_busy_next = i_set_mask | (r_busy & ~i_clr_mask);
        end
    end

    // Counter follows the vector by counting individual 0->1 and 1->0 edges.
    always_comb begin
        w_cnt_next = r_cnt;
        for (int r = 0; r < NREG; r++) begin
            if (!r_busy[r] && w_busy_next[r]) begin
                w_cnt_next = w_cnt_next + CNT_ONE;
            end else if (r_busy[r] && !w_busy_next[r]) begin
                w_cnt_next = w_cnt_next - CNT_ONE;
            end
        end
    end

    // Busy state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            r_busy <= w_busy_next;
            r_cnt  <= w_cnt_next;
        end
    end

    assign o_busy     = r_busy;
    assign o_busy_cnt = r_cnt;
    assign o_any_busy = (r_cnt != '0);

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port integer register file: flop storage, highest-port-wins write
// resolution, write-to-read bypass and busy lookup through the scoreboard.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int  DW   = DEF_DW,
    parameter int  NREG = DEF_NREG,
    parameter int  NR   = DEF_NR,
    parameter int  NW   = DEF_NW,
    localparam int AW   = $clog2(NREG)
) (
    input  logic         clk,
    input  logic         reset_n,
    reg_file_sb_if.slave bus
);

    logic [NREG-1:0][DW-1:0] r_regs;
    logic [NREG-1:0][DW-1:0] w_wr_val;
    logic [NREG-1:0]         w_wr_hit;
    logic [NREG-1:0]         w_sb_set_mask;
    logic [NREG-1:0]         w_busy;

    genvar gi;

    // Per-register decode of the write ports and of the scoreboard set.
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_wr_resolve
            logic          w_hit;
            logic [DW-1:0] w_val;

            // Scan ports in ascending order so the highest matching index wins.
            always_comb begin
                w_hit = 1'b0;
                w_val = '0;
                for (int j = 0; j < NW; j++) begin
                    if (bus.wr_en[j] &&
                        (bus.wr_addr[port_slice(j, AW) +: AW] == AW'(gi))) begin
                        w_hit = 1'b1;
                        w_val = bus.wr_data[port_slice(j, DW) +: DW];
                    end
                end
            end

            assign w_wr_hit[gi]      = (gi != REG_ZERO) && w_hit;
            assign w_wr_val[gi]      = w_val;
            assign w_sb_set_mask[gi] = (gi != REG_ZERO) && bus.sb_set &&
                                       (bus.sb_addr == AW'(gi));
        end
    endgenerate

    // Data storage; register 0 is never written after reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_regs <= '0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (w_wr_hit[r]) begin
                    r_regs[r] <= w_wr_val[r];
                end
            end
        end
    end

    // Combinational read ports with bypass from this cycle's winning write.
    generate
        for (gi = 0; gi < NR; gi++) begin : g_rd_port
            logic [AW-1:0] w_addr;
            logic [DW-1:0] w_data;
            logic          w_busy_rd;

            assign w_addr = bus.rd_addr[port_slice(gi, AW) +: AW];

            // A landing write both supplies the data and hides the busy flag.
            always_comb begin
                w_data    = '0;
                w_busy_rd = 1'b0;
                if (w_addr != AW'(REG_ZERO)) begin
                    w_data    = w_wr_hit[w_addr] ? w_wr_val[w_addr] : r_regs[w_addr];
                    w_busy_rd = w_busy[w_addr] && !w_wr_hit[w_addr];
                end
            end

            assign bus.rd_data[port_slice(gi, DW) +: DW] = w_data;
            assign bus.rd_busy[gi]                       = w_busy_rd;
        end
    endgenerate

    reg_scoreboard #(
        .NREG (NREG)
    ) u_scoreboard (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_set_mask (w_sb_set_mask),
        .i_clr_mask (w_wr_hit),
        .i_flush    (bus.sb_flush),
        .o_busy     (w_busy),
        .o_busy_cnt (bus.busy_cnt),
        .o_any_busy (bus.any_busy)
    );

endmodule
